// File: rtl/sd_buf_sched_if.sv
// Handshake bundle between the ping-pong buffer scheduler and its three stages
// (SD read fill, OTP XOR, SD write drain).
interface sd_buf_sched_if #(
  parameter int BLK_CNT_W = 20
);
  logic                 iabort;
  logic                 ifill_req;
  logic                 ifill_done;
  logic                 ixor_req;
  logic                 ixor_done;
  logic                 idrain_req;
  logic                 idrain_done;
  logic                 ofill_start;
  logic                 ofill_bank;
  logic                 oxor_start;
  logic                 oxor_bank;
  logic                 odrain_start;
  logic                 odrain_bank;
  logic                 oempty;
  logic                 ofull;
  logic                 oerr;
  logic [BLK_CNT_W-1:0] oblk_cnt;

  modport master (
    output iabort, ifill_req, ifill_done, ixor_req, ixor_done, idrain_req, idrain_done,
    input  ofill_start, ofill_bank, oxor_start, oxor_bank, odrain_start, odrain_bank,
    input  oempty, ofull, oerr, oblk_cnt
  );

  modport slave (
    input  iabort, ifill_req, ifill_done, ixor_req, ixor_done, idrain_req, idrain_done,
    output ofill_start, ofill_bank, oxor_start, oxor_bank, odrain_start, odrain_bank,
    output oempty, ofull, oerr, oblk_cnt
  );
endinterface

// File: rtl/sd_buf_sched.sv
// Ping-pong scheduler for two 512-byte block buffers: each bank cycles
// FREE -> FILL -> FULL -> XOR -> READY -> DRAIN -> FREE, with the stages served in bank order.
module sd_buf_sched #(
  parameter int BLK_CNT_W = 20
) (
  input logic           iclk,
  input logic           irst,
  sd_buf_sched_if.slave bus
);

  typedef enum logic [2:0] {
    BANK_FREE  = 3'd0,
    BANK_FILL  = 3'd1,
    BANK_FULL  = 3'd2,
    BANK_XOR   = 3'd3,
    BANK_READY = 3'd4,
    BANK_DRAIN = 3'd5
  } bank_state_t;

  localparam int NSTAGE = 3;

  bank_state_t          bank_q [2];
  bank_state_t          bank_d [2];
  logic [NSTAGE-1:0]    busy_q, busy_d;
  logic [NSTAGE-1:0]    ptr_q, ptr_d;
  logic [NSTAGE-1:0]    sel_q, sel_d;
  logic [NSTAGE-1:0]    start_q, start_d;
  logic [NSTAGE-1:0]    grant;
  logic [NSTAGE-1:0]    req;
  logic [NSTAGE-1:0]    done;
  logic                 err_q, err_d;
  logic [BLK_CNT_W-1:0] cnt_q, cnt_d;

  // Stage index 0 = fill, 1 = xor, 2 = drain.
  function automatic bank_state_t wait_state(input int s);
    case (s)
      0:       return BANK_FREE;
      1:       return BANK_FULL;
      default: return BANK_READY;
    endcase
  endfunction

  function automatic bank_state_t run_state(input int s);
    case (s)
      0:       return BANK_FILL;
      1:       return BANK_XOR;
      default: return BANK_DRAIN;
    endcase
  endfunction

  function automatic bank_state_t after_state(input int s);
    case (s)
      0:       return BANK_FULL;
      1:       return BANK_READY;
      default: return BANK_FREE;
    endcase
  endfunction

  assign req  = {bus.idrain_req, bus.ixor_req, bus.ifill_req};
  assign done = {bus.idrain_done, bus.ixor_done, bus.ifill_done};

  always_ff @(posedge iclk) begin
    if (irst) begin
      bank_q[0] <= BANK_FREE;
      bank_q[1] <= BANK_FREE;
      busy_q    <= '0;
      ptr_q     <= '0;
      sel_q     <= '0;
      start_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      bank_q    <= bank_d;
      busy_q    <= busy_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      start_q   <= start_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Stages never target the same bank in one cycle: the eligible and active states are disjoint.
  always_comb begin
    bank_d  = bank_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    start_d = '0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    grant   = '0;

    for (int s = 0; s < NSTAGE; s++) begin
      grant[s] = !busy_q[s] && req[s] && (bank_q[ptr_q[s]] == wait_state(s));

      if (done[s]) begin
        if (busy_q[s]) begin
          bank_d[ptr_q[s]] = after_state(s);
          busy_d[s]        = 1'b0;
          ptr_d[s]         = ~ptr_q[s];
        end else begin
          err_d = 1'b1;
        end
      end

      if (grant[s]) begin
        bank_d[ptr_q[s]] = run_state(s);
        busy_d[s]        = 1'b1;
        sel_d[s]         = ptr_q[s];
        start_d[s]       = 1'b1;
      end
    end

    if (done[2] && busy_q[2]) begin
      cnt_d = cnt_q + 1'b1;
    end

    // Abort wins over everything else but keeps the block count and the last bank indices.
    if (bus.iabort) begin
      bank_d[0] = BANK_FREE;
      bank_d[1] = BANK_FREE;
      busy_d    = '0;
      ptr_d     = '0;
      start_d   = '0;
      err_d     = 1'b0;
    end
  end

  assign bus.ofill_start  = start_q[0];
  assign bus.oxor_start   = start_q[1];
  assign bus.odrain_start = start_q[2];
  assign bus.ofill_bank   = sel_q[0];
  assign bus.oxor_bank    = sel_q[1];
  assign bus.odrain_bank  = sel_q[2];
  assign bus.oempty       = (bank_q[0] == BANK_FREE) && (bank_q[1] == BANK_FREE);
  assign bus.ofull        = (bank_q[0] != BANK_FREE) && (bank_q[1] != BANK_FREE);
  assign bus.oerr         = err_q;
  assign bus.oblk_cnt     = cnt_q;

endmodule

// File: tb/tb_sd_buf_sched.sv
// Directed bench for sd_buf_sched: per-stage scoreboards of expected grant banks,
// plus a 2-bit-counter twin instance fed the same stimulus to exercise wrap.
module tb_sd_buf_sched;

  localparam int W = 20;

  logic iclk = 1'b0;
  logic irst = 1'b1;
  always #5 iclk = ~iclk;

  sd_buf_sched_if #(.BLK_CNT_W(W)) b ();
  sd_buf_sched_if #(.BLK_CNT_W(2)) b2 ();

  sd_buf_sched #(.BLK_CNT_W(W)) dut    (.iclk(iclk), .irst(irst), .bus(b));
  sd_buf_sched #(.BLK_CNT_W(2)) dut_w2 (.iclk(iclk), .irst(irst), .bus(b2));

  assign b2.iabort      = b.iabort;
  assign b2.ifill_req   = b.ifill_req;
  assign b2.ifill_done  = b.ifill_done;
  assign b2.ixor_req    = b.ixor_req;
  assign b2.ixor_done   = b.ixor_done;
  assign b2.idrain_req  = b.idrain_req;
  assign b2.idrain_done = b.idrain_done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int exp_cnt  = 0;

  int fill_q[$];
  int xor_q[$];
  int drain_q[$];

  int   left[3];
  int   cd[3];
  int   grants[3];
  int   dones[3];
  int   post[3];
  int   start_cyc[3];
  int   done_cyc[3];
  logic held_bank[3];
  bit   drain_en;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic getStart(input int s);
    case (s)
      0:       return b.ofill_start;
      1:       return b.oxor_start;
      default: return b.odrain_start;
    endcase
  endfunction

  function automatic logic getBank(input int s);
    case (s)
      0:       return b.ofill_bank;
      1:       return b.oxor_bank;
      default: return b.odrain_bank;
    endcase
  endfunction

  task automatic setReq(input int s, input logic v);
    case (s)
      0:       b.ifill_req  = v;
      1:       b.ixor_req   = v;
      default: b.idrain_req = v;
    endcase
  endtask

  task automatic setDone(input int s, input logic v);
    case (s)
      0:       b.ifill_done  = v;
      1:       b.ixor_done   = v;
      default: b.idrain_done = v;
    endcase
  endtask

  task automatic pushExp(input int s, input int v);
    case (s)
      0:       fill_q.push_back(v);
      1:       xor_q.push_back(v);
      default: drain_q.push_back(v);
    endcase
  endtask

  task automatic popExp(input int s, output int v, output bit ok);
    ok = 1'b0;
    v  = 0;
    case (s)
      0:       if (fill_q.size()  > 0) begin v = fill_q.pop_front();  ok = 1'b1; end
      1:       if (xor_q.size()   > 0) begin v = xor_q.pop_front();   ok = 1'b1; end
      default: if (drain_q.size() > 0) begin v = drain_q.pop_front(); ok = 1'b1; end
    endcase
  endtask

  function automatic int afterState(input int s);
    return (s == 0) ? 2 : (s == 1) ? 4 : 0;
  endfunction

  task automatic resetEngine();
    for (int s = 0; s < 3; s++) begin
      left[s]   = 0;
      cd[s]     = -1;
      grants[s] = 0;
      dones[s]  = 0;
      post[s]   = -1;
    end
    drain_en = 1'b0;
  endtask

  // One cycle of the three stage engines: check grants against the scoreboard, then drive requests/dones.
  task automatic applyStimulus(input int lat);
    bit started[3];
    int e;
    bit ok;
    @(negedge iclk);
    cyc++;
    for (int s = 0; s < 3; s++) begin
      started[s] = 1'b0;
      if (post[s] >= 0) begin
        checkOutput($sformatf("bank%0d_after_done_s%0d", post[s], s), 32'(dut.bank_q[post[s]]), afterState(s));
        post[s] = -1;
      end
      if (getStart(s)) begin
        popExp(s, e, ok);
        if (!ok) begin
          checkOutput($sformatf("unexpected_start_s%0d", s), 32'd1, 32'd0);
        end else begin
          checkOutput($sformatf("grant_bank_s%0d", s), 32'(getBank(s)), e);
          checkOutput($sformatf("active_state_s%0d", s), 32'(dut.bank_q[e]), 2 * s + 1);
        end
        held_bank[s] = getBank(s);
        start_cyc[s] = cyc;
        cd[s]        = lat;
        started[s]   = 1'b1;
        grants[s]++;
        left[s]--;
      end
    end
    for (int s = 0; s < 3; s++) begin
      setDone(s, 1'b0);
      if (!started[s] && cd[s] > 0) begin
        cd[s]--;
        if (cd[s] == 0) begin
          setDone(s, 1'b1);
          checkOutput($sformatf("bank_held_s%0d", s), 32'(getBank(s)), 32'(held_bank[s]));
          post[s]     = held_bank[s];
          done_cyc[s] = cyc;
          cd[s]       = -1;
          dones[s]++;
          if (s == 2) exp_cnt++;
        end
      end
    end
    setReq(0, left[0] > 0);
    setReq(1, left[1] > 0);
    setReq(2, drain_en && (left[2] > 0));
  endtask

  task automatic runUntil(input int s, input int target, input int lat, input int budget, input string tag);
    int n;
    n = 0;
    while (dones[s] < target && n < budget) begin
      applyStimulus(lat);
      n++;
    end
    if (dones[s] < target) checkOutput({tag, "_timeout"}, 32'(dones[s]), 32'(target));
    for (int i = 0; i < 3; i++) applyStimulus(lat);
  endtask

  task automatic grantOne(input int s, input int exp_bank, input string tag);
    int  n;
    int  e;
    bit  ok;
    pushExp(s, exp_bank);
    setReq(s, 1'b1);
    n = 0;
    do begin
      @(negedge iclk);
      cyc++;
      n++;
    end while (!getStart(s) && n < 20);
    setReq(s, 1'b0);
    popExp(s, e, ok);
    if (!getStart(s)) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    else              checkOutput(tag, 32'(getBank(s)), e);
  endtask

  task automatic pulseDone(input logic [2:0] mask);
    for (int s = 0; s < 3; s++) setDone(s, mask[s]);
    @(negedge iclk);
    cyc++;
    for (int s = 0; s < 3; s++) setDone(s, 1'b0);
  endtask

  task automatic pulseAbort();
    b.iabort = 1'b1;
    @(negedge iclk);
    cyc++;
    b.iabort = 1'b0;
  endtask

  initial begin
    int c0;
    b.iabort = 1'b0;
    b.ifill_req = 1'b0;  b.ifill_done = 1'b0;
    b.ixor_req = 1'b0;   b.ixor_done = 1'b0;
    b.idrain_req = 1'b0; b.idrain_done = 1'b0;
    resetEngine();

    irst = 1'b1;
    @(negedge iclk);
    @(negedge iclk);
    irst = 1'b0;
    checkOutput("rst_empty", 32'(b.oempty), 32'd1);
    checkOutput("rst_full", 32'(b.ofull), 32'd0);
    checkOutput("rst_err", 32'(b.oerr), 32'd0);
    checkOutput("rst_cnt", 32'(b.oblk_cnt), 32'd0);
    checkOutput("rst_starts", 32'({b.ofill_start, b.oxor_start, b.odrain_start}), 32'd0);

    // Single block through all three stages, done 5 cycles after each start.
    $display("[TB] single block");
    resetEngine();
    for (int s = 0; s < 3; s++) begin
      pushExp(s, 0);
      left[s] = 1;
    end
    drain_en = 1'b1;
    applyStimulus(5);
    c0 = cyc;
    runUntil(2, 1, 5, 100, "single");
    checkOutput("single_fill_latency", 32'(start_cyc[0] - c0), 32'd1);
    checkOutput("single_xor_handoff", 32'(start_cyc[1] - done_cyc[0]), 32'd2);
    checkOutput("single_drain_handoff", 32'(start_cyc[2] - done_cyc[1]), 32'd2);
    checkOutput("single_cnt", 32'(b.oblk_cnt), 32'(exp_cnt));
    checkOutput("single_empty", 32'(b.oempty), 32'd1);
    checkOutput("single_w2_cnt", 32'(b2.oblk_cnt), 32'(exp_cnt % 4));

    // Ping-pong: six blocks with drain held off until both banks are READY.
    $display("[TB] ping-pong");
    pulseAbort();
    resetEngine();
    for (int i = 0; i < 6; i++) begin
      for (int s = 0; s < 3; s++) pushExp(s, i % 2);
    end
    for (int s = 0; s < 3; s++) left[s] = 6;
    runUntil(1, 2, 3, 200, "pp_phase_a");
    checkOutput("pp_full", 32'(b.ofull), 32'd1);
    checkOutput("pp_fill_waiting", 32'(grants[0]), 32'd2);
    checkOutput("pp_wait_no_err", 32'(b.oerr), 32'd0);
    checkOutput("pp_bank0_ready", 32'(dut.bank_q[0]), 32'd4);
    checkOutput("pp_bank1_ready", 32'(dut.bank_q[1]), 32'd4);
    drain_en = 1'b1;
    runUntil(2, 6, 2, 600, "pp_phase_b");
    checkOutput("pp_cnt", 32'(b.oblk_cnt), 32'(exp_cnt));
    checkOutput("pp_empty", 32'(b.oempty), 32'd1);
    checkOutput("pp_fill_grants", 32'(grants[0]), 32'd6);
    checkOutput("pp_drain_grants", 32'(grants[2]), 32'd6);
    checkOutput("pp_scoreboard_left", 32'(fill_q.size() + xor_q.size() + drain_q.size()), 32'd0);
    checkOutput("pp_w2_cnt_wrap", 32'(b2.oblk_cnt), 32'(exp_cnt % 4));
    checkOutput("pp_err", 32'(b.oerr), 32'd0);

    // fill_done on bank 1 and drain_done on bank 0 in the same cycle.
    $display("[TB] simultaneous done");
    resetEngine();
    pulseAbort();
    grantOne(0, 0, "sim_fill0");
    pulseDone(3'b001);
    grantOne(1, 0, "sim_xor0");
    pulseDone(3'b010);
    grantOne(2, 0, "sim_drain0");
    grantOne(0, 1, "sim_fill1");
    pulseDone(3'b101);
    exp_cnt++;
    checkOutput("sim_bank0_free", 32'(dut.bank_q[0]), 32'd0);
    checkOutput("sim_bank1_full", 32'(dut.bank_q[1]), 32'd2);
    checkOutput("sim_cnt", 32'(b.oblk_cnt), 32'(exp_cnt));
    checkOutput("sim_w2_cnt", 32'(b2.oblk_cnt), 32'(exp_cnt % 4));
    checkOutput("sim_err", 32'(b.oerr), 32'd0);

    // Done with the XOR stage idle is a protocol error and leaves banks untouched.
    $display("[TB] error and abort");
    pulseDone(3'b010);
    checkOutput("err_set", 32'(b.oerr), 32'd1);
    checkOutput("err_bank0", 32'(dut.bank_q[0]), 32'd0);
    checkOutput("err_bank1", 32'(dut.bank_q[1]), 32'd2);
    pulseAbort();
    checkOutput("abort_err_clr", 32'(b.oerr), 32'd0);
    checkOutput("abort_empty", 32'(b.oempty), 32'd1);
    checkOutput("abort_cnt_kept", 32'(b.oblk_cnt), 32'(exp_cnt));
    pulseDone(3'b001);
    checkOutput("late_done_err", 32'(b.oerr), 32'd1);
    pulseAbort();

    // Abort in the middle of a fill; the pointer restarts at bank 0.
    grantOne(0, 0, "midfill_grant");
    pulseAbort();
    checkOutput("midfill_empty", 32'(b.oempty), 32'd1);
    checkOutput("midfill_cnt", 32'(b.oblk_cnt), 32'(exp_cnt));
    grantOne(0, 0, "midfill_regrant");
    pulseAbort();

    // Done in the same cycle as the grant decision for that stage.
    b.ifill_req  = 1'b1;
    b.ifill_done = 1'b1;
    @(negedge iclk);
    cyc++;
    b.ifill_req  = 1'b0;
    b.ifill_done = 1'b0;
    checkOutput("grant_done_start", 32'(b.ofill_start), 32'd1);
    checkOutput("grant_done_err", 32'(b.oerr), 32'd1);
    @(negedge iclk);
    checkOutput("start_one_cycle", 32'(b.ofill_start), 32'd0);
    pulseAbort();

    irst = 1'b1;
    @(negedge iclk);
    irst = 1'b0;
    checkOutput("final_rst_cnt", 32'(b.oblk_cnt), 32'd0);
    checkOutput("final_rst_w2_cnt", 32'(b2.oblk_cnt), 32'd0);
    checkOutput("final_rst_empty", 32'(b.oempty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
